// File: rtl/systolic_drain.sv
// Deskews per-column systolic array results into aligned rows and buffers them in a row FIFO.
// Define SYSTOLIC_DRAIN_RELU_EN to clamp negative elements to zero before they are buffered.
module systolic_drain #(
    parameter int unsigned SYSTOLIC_ARRAY_WIDTH = 2,
    parameter int unsigned ROW_FIFO_DEPTH       = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [31:0] sys_data_out [SYSTOLIC_ARRAY_WIDTH],
    input  logic               sys_valid_out [SYSTOLIC_ARRAY_WIDTH],
    input  logic        [15:0] ub_rd_col_size_in,
    input  logic               ub_rd_col_size_valid_in,
    output logic signed [31:0] row_data [SYSTOLIC_ARRAY_WIDTH],
    output logic               row_valid,
    input  logic               row_ready,
    output logic        [15:0] rows_out_cnt,
    output logic               overflow_err,
    output logic               skew_err
);

    localparam int unsigned N     = SYSTOLIC_ARRAY_WIDTH;
    localparam int unsigned AddrW = $clog2(ROW_FIFO_DEPTH);

    localparam logic [15:0]      NCol     = 16'(N);
    localparam logic [AddrW-1:0] PtrOne   = AddrW'(1);
    localparam logic [AddrW:0]   CntOne   = (AddrW + 1)'(1);
    localparam logic [AddrW:0]   CntFull  = (AddrW + 1)'(ROW_FIFO_DEPTH);
    localparam logic [15:0]      RowsOne  = 16'd1;

    logic signed [31:0] aligned_data  [N];
    logic               aligned_valid [N];
    logic               col_en        [N];
    logic signed [31:0] wr_row        [N];
    logic signed [31:0] mem_q [ROW_FIFO_DEPTH][N];

    logic [15:0]      col_size_q;
    logic [AddrW-1:0] wptr_q, rptr_q;
    logic [AddrW:0]   count_q;
    logic             skew_hit;
    logic             push, pop, full, push_ok;

    // Column c waits N-1-c cycles so every element of a row lines up with the last column.
    for (genvar c = 0; c < N; c++) begin : g_col
        assign col_en[c] = (32'(c) < 32'(col_size_q));

        if (c == N - 1) begin : g_pass
            assign aligned_data[c]  = sys_data_out[c];
            assign aligned_valid[c] = sys_valid_out[c];
        end else begin : g_dly
            localparam int unsigned Stages = N - 1 - c;

            logic signed [31:0] data_q  [Stages];
            logic               valid_q [Stages];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int unsigned s = 0; s < Stages; s++) begin
                        data_q[s]  <= '0;
                        valid_q[s] <= 1'b0;
                    end
                end else begin
                    data_q[0]  <= sys_data_out[c];
                    valid_q[0] <= sys_valid_out[c];
                    for (int unsigned s = 1; s < Stages; s++) begin
                        data_q[s]  <= data_q[s-1];
                        valid_q[s] <= valid_q[s-1];
                    end
                end
            end

            assign aligned_data[c]  = data_q[Stages-1];
            assign aligned_valid[c] = valid_q[Stages-1];
        end
    end

    always_comb begin
        skew_hit = 1'b0;
        for (int unsigned c = 0; c < N; c++) begin
            wr_row[c] = col_en[c] ? aligned_data[c] : '0;
`ifdef SYSTOLIC_DRAIN_RELU_EN
            if (wr_row[c][31]) begin
                wr_row[c] = '0;
            end
`endif
            if (col_en[c] && (aligned_valid[c] != aligned_valid[0])) begin
                skew_hit = 1'b1;
            end
        end
    end

    // Column 0 is always enabled, so it alone decides whether a row is pushed.
    assign push    = aligned_valid[0];
    assign row_valid = (count_q != '0);
    assign pop     = row_valid && row_ready;
    assign full    = (count_q == CntFull);
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_size_q   <= NCol;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            rows_out_cnt <= '0;
            overflow_err <= 1'b0;
            skew_err     <= 1'b0;
        end else begin
            if (ub_rd_col_size_valid_in) begin
                col_size_q <= ((ub_rd_col_size_in == 16'd0) || (ub_rd_col_size_in > NCol)) ?
                              NCol : ub_rd_col_size_in;
            end
            if (push_ok) begin
                wptr_q <= wptr_q + PtrOne;
            end
            if (pop) begin
                rptr_q       <= rptr_q + PtrOne;
                rows_out_cnt <= rows_out_cnt + RowsOne;
            end
            unique case ({push_ok, pop})
                2'b10:   count_q <= count_q + CntOne;
                2'b01:   count_q <= count_q - CntOne;
                default: count_q <= count_q;
            endcase
            if (push && full && !pop) begin
                overflow_err <= 1'b1;
            end
            if (skew_hit) begin
                skew_err <= 1'b1;
            end
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            for (int unsigned c = 0; c < N; c++) begin
                mem_q[wptr_q][c] <= wr_row[c];
            end
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < N; c++) begin
            row_data[c] = row_valid ? mem_q[rptr_q][c] : '0;
        end
    end

endmodule

// File: tb/tb_systolic_drain.sv
// Bench for systolic_drain: directed vector table, randomized run against a queue model,
// and an asynchronous-reset sequence.
module tb_systolic_drain;

    localparam int unsigned N     = 2;
    localparam int unsigned Depth = 4;
    localparam int unsigned W     = 32 * N;

`ifdef SYSTOLIC_DRAIN_RELU_EN
    localparam int NegExp = 0;
`else
    localparam int NegExp = -5;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [31:0] sys_data_out [N];
    logic               sys_valid_out [N];
    logic        [15:0] ub_rd_col_size_in;
    logic               ub_rd_col_size_valid_in;
    logic signed [31:0] row_data [N];
    logic               row_valid;
    logic               row_ready;
    logic        [15:0] rows_out_cnt;
    logic               overflow_err;
    logic               skew_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    systolic_drain #(
        .SYSTOLIC_ARRAY_WIDTH (N),
        .ROW_FIFO_DEPTH       (Depth)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .sys_data_out            (sys_data_out),
        .sys_valid_out           (sys_valid_out),
        .ub_rd_col_size_in       (ub_rd_col_size_in),
        .ub_rd_col_size_valid_in (ub_rd_col_size_valid_in),
        .row_data                (row_data),
        .row_valid               (row_valid),
        .row_ready               (row_ready),
        .rows_out_cnt            (rows_out_cnt),
        .overflow_err            (overflow_err),
        .skew_err                (skew_err)
    );

    typedef logic [N-1:0][31:0] row_t;
    typedef struct packed {
        logic [N-1:0] v;
        row_t         d;
    } in_t;

    typedef struct {
        bit          rs;
        bit          ld;
        logic [15:0] cs;
        bit          v0;
        int          d0;
        bit          v1;
        int          d1;
        bit          rdy;
        bit          ev;
        int          e0;
        int          e1;
        int          ecnt;
        bit          eovf;
        bit          eskew;
    } vec_t;

    vec_t tbl[$];

    // Reference model state
    in_t  hist[$];
    row_t mq[$];
    int   m_cnt;
    bit   m_ovf;
    bit   m_skew;
    int   m_cs;

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic row_t pack_row();
        row_t r;
        for (int c = 0; c < N; c++) r[c] = row_data[c];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] v, input row_t d, input bit ld,
                         input logic [15:0] cs, input bit rdy);
        for (int c = 0; c < N; c++) begin
            sys_valid_out[c] = v[c];
            sys_data_out[c]  = d[c];
        end
        ub_rd_col_size_valid_in = ld;
        ub_rd_col_size_in       = cs;
        row_ready               = rdy;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive('0, '0, 1'b0, 16'd0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
    endtask

    function automatic void add(bit rs, bit ld, logic [15:0] cs, bit v0, int d0, bit v1, int d1,
                                bit rdy, bit ev, int e0, int e1, int ecnt, bit eovf, bit eskew);
        vec_t x;
        x.rs = rs; x.ld = ld; x.cs = cs; x.v0 = v0; x.d0 = d0; x.v1 = v1; x.d1 = d1;
        x.rdy = rdy; x.ev = ev; x.e0 = e0; x.e1 = e1; x.ecnt = ecnt; x.eovf = eovf;
        x.eskew = eskew;
        tbl.push_back(x);
    endfunction

    task automatic model_reset();
        hist.delete();
        mq.delete();
        m_cnt  = 0;
        m_ovf  = 1'b0;
        m_skew = 1'b0;
        m_cs   = N;
    endtask

    task automatic model_check(input string tag);
        row_t exp_row;
        exp_row = (mq.size() != 0) ? mq[0] : '0;
        chk({tag, ".row_valid"}, W'(row_valid), W'(mq.size() != 0));
        chk({tag, ".row_data"}, pack_row(), exp_row);
        chk({tag, ".rows_out_cnt"}, W'(rows_out_cnt), W'(m_cnt));
        chk({tag, ".overflow_err"}, W'(overflow_err), W'(m_ovf));
        chk({tag, ".skew_err"}, W'(skew_err), W'(m_skew));
    endtask

    // Row element in column c leaves the array c cycles after column 0 and is buffered
    // once the last column of that row has arrived.
    task automatic model_step(input in_t x, input bit ld, input logic [15:0] cs, input bit rdy);
        row_t         ad;
        logic [N-1:0] av;
        in_t          e;
        bit           pop;
        int           back;
        hist.push_back(x);
        if (hist.size() > N) void'(hist.pop_front());
        for (int c = 0; c < N; c++) begin
            back = N - 1 - c;
            if (hist.size() > back) begin
                e     = hist[hist.size() - 1 - back];
                av[c] = e.v[c];
                ad[c] = e.d[c];
            end else begin
                av[c] = 1'b0;
                ad[c] = '0;
            end
            if (c >= m_cs) ad[c] = '0;
`ifdef SYSTOLIC_DRAIN_RELU_EN
            if ($signed(ad[c]) < 0) ad[c] = '0;
`endif
        end
        for (int c = 1; c < m_cs; c++) begin
            if (av[c] != av[0]) m_skew = 1'b1;
        end
        pop = (mq.size() > 0) && rdy;
        if (pop) begin
            void'(mq.pop_front());
            m_cnt = (m_cnt + 1) % 65536;
        end
        if (av[0]) begin
            if (mq.size() < Depth) mq.push_back(ad);
            else m_ovf = 1'b1;
        end
        if (ld) m_cs = ((cs == 0) || (cs > N)) ? N : int'(cs);
    endtask

    task automatic run_cycle(input string tag, input in_t x, input bit ld, input logic [15:0] cs,
                             input bit rdy);
        model_check(tag);
        drive(x.v, x.d, ld, cs, rdy);
        model_step(x, ld, cs, rdy);
        tick();
    endtask

    initial begin
        in_t  x;
        bit   rq[$];
        bit   ld;
        bit   rdy;
        logic [15:0] cs;

        drive('0, '0, 1'b0, 16'd0, 1'b0);

        // Two-column row pair with full enable
        add(1, 0, 0,  1, 24, 0,  0, 1,  0,  0,  0, 0, 0, 0);
        add(0, 0, 0,  1, 48, 1, 35, 1,  0,  0,  0, 0, 0, 0);
        add(0, 0, 0,  0,  0, 1, 70, 1,  1, 24, 35, 0, 0, 0);
        add(0, 0, 0,  0,  0, 0,  0, 1,  1, 48, 70, 1, 0, 0);
        add(0, 0, 0,  0,  0, 0,  0, 1,  0,  0,  0, 2, 0, 0);
        // Only column 0 enabled
        add(1, 1, 1,  0,  0, 0,  0, 1,  0,  0,  0, 0, 0, 0);
        add(0, 0, 0,  1, 24, 0,  0, 1,  0,  0,  0, 0, 0, 0);
        add(0, 0, 0,  1, 48, 1, 35, 1,  0,  0,  0, 0, 0, 0);
        add(0, 0, 0,  0,  0, 1, 70, 1,  1, 24,  0, 0, 0, 0);
        add(0, 0, 0,  0,  0, 0,  0, 1,  1, 48,  0, 1, 0, 0);
        add(0, 0, 0,  0,  0, 0,  0, 1,  0,  0,  0, 2, 0, 0);
        // Column-size saturation (5 -> N) and zero-as-N
        add(1, 1, 1,  0,  0, 0,  0, 1,  0,  0,  0, 0, 0, 0);
        add(0, 1, 5,  0,  0, 0,  0, 1,  0,  0,  0, 0, 0, 0);
        add(0, 0, 0,  1, 24, 0,  0, 1,  0,  0,  0, 0, 0, 0);
        add(0, 0, 0,  1, 48, 1, 35, 1,  0,  0,  0, 0, 0, 0);
        add(0, 0, 0,  0,  0, 1, 70, 1,  1, 24, 35, 0, 0, 0);
        add(0, 1, 1,  0,  0, 0,  0, 1,  1, 48, 70, 1, 0, 0);
        add(0, 1, 0,  0,  0, 0,  0, 1,  0,  0,  0, 2, 0, 0);
        add(0, 0, 0,  1,  5, 0,  0, 1,  0,  0,  0, 2, 0, 0);
        add(0, 0, 0,  0,  0, 1,  6, 1,  0,  0,  0, 2, 0, 0);
        add(0, 0, 0,  0,  0, 0,  0, 1,  1,  5,  6, 2, 0, 0);
        add(0, 0, 0,  0,  0, 0,  0, 1,  0,  0,  0, 3, 0, 0);
        // Column 1 one cycle late
        add(1, 0, 0,  1,  1, 0,  0, 0,  0,  0,  0, 0, 0, 0);
        add(0, 0, 0,  0,  0, 0,  0, 0,  0,  0,  0, 0, 0, 0);
        add(0, 0, 0,  0,  0, 1,  2, 0,  1,  1,  0, 0, 0, 1);
        add(0, 0, 0,  0,  0, 0,  0, 0,  1,  1,  0, 0, 0, 1);
        // Five rows into a four-entry FIFO, then drain
        add(1, 0, 0,  1, 10, 0,  0, 0,  0,  0,  0, 0, 0, 0);
        add(0, 0, 0,  1, 11, 1, 20, 0,  0,  0,  0, 0, 0, 0);
        add(0, 0, 0,  1, 12, 1, 21, 0,  1, 10, 20, 0, 0, 0);
        add(0, 0, 0,  1, 13, 1, 22, 0,  1, 10, 20, 0, 0, 0);
        add(0, 0, 0,  1, 14, 1, 23, 0,  1, 10, 20, 0, 0, 0);
        add(0, 0, 0,  0,  0, 1, 24, 0,  1, 10, 20, 0, 0, 0);
        add(0, 0, 0,  0,  0, 0,  0, 1,  1, 10, 20, 0, 1, 0);
        add(0, 0, 0,  0,  0, 0,  0, 1,  1, 11, 21, 1, 1, 0);
        add(0, 0, 0,  0,  0, 0,  0, 1,  1, 12, 22, 2, 1, 0);
        add(0, 0, 0,  0,  0, 0,  0, 1,  1, 13, 23, 3, 1, 0);
        add(0, 0, 0,  0,  0, 0,  0, 1,  0,  0,  0, 4, 1, 0);
        // Negative element, clamped only in the ReLU build
        add(1, 0, 0,  1, -5, 0,  0, 0,  0,  0,  0, 0, 0, 0);
        add(0, 0, 0,  0,  0, 1,  7, 0,  0,  0,  0, 0, 0, 0);
        add(0, 0, 0,  0,  0, 0,  0, 0,  1, NegExp, 7, 0, 0, 0);
        add(0, 0, 0,  0,  0, 0,  0, 1,  1, NegExp, 7, 0, 0, 0);
        add(0, 0, 0,  0,  0, 0,  0, 1,  0,  0,  0, 1, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rs) do_reset();
            chk($sformatf("tbl%0d.row_valid", i), W'(row_valid), W'(tbl[i].ev));
            chk($sformatf("tbl%0d.row_data", i), pack_row(), {tbl[i].e1, tbl[i].e0});
            chk($sformatf("tbl%0d.rows_out_cnt", i), W'(rows_out_cnt), W'(tbl[i].ecnt));
            chk($sformatf("tbl%0d.overflow_err", i), W'(overflow_err), W'(tbl[i].eovf));
            chk($sformatf("tbl%0d.skew_err", i), W'(skew_err), W'(tbl[i].eskew));
            drive({tbl[i].v1, tbl[i].v0}, {tbl[i].d1, tbl[i].d0}, tbl[i].ld, tbl[i].cs,
                  tbl[i].rdy);
            tick();
        end

        // Randomized traffic: mostly well-skewed rows, rare valid glitches, varying column size
        do_reset();
        model_reset();
        for (int i = 0; i < 500; i++) begin
            if (i == 250) begin
                do_reset();
                model_reset();
                rq.delete();
            end
            rq.push_front($urandom_range(0, 2) != 0);
            if (rq.size() > N) void'(rq.pop_back());
            for (int c = 0; c < N; c++) begin
                x.v[c] = (c < rq.size()) ? rq[c] : 1'b0;
                if ($urandom_range(0, 299) == 0) x.v[c] = ~x.v[c];
                x.d[c] = $urandom;
            end
            ld  = ($urandom_range(0, 15) == 0);
            cs  = 16'($urandom_range(0, 4));
            rdy = (((i / 40) % 2) == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            run_cycle($sformatf("rnd%0d", i), x, ld, cs, rdy);
        end

        // Asynchronous reset with two rows buffered and one already consumed
        do_reset();
        model_reset();
        x.v = 2'b01; x.d = {32'd0,  32'd1}; run_cycle("ar0", x, 1'b0, 16'd0, 1'b0);
        x.v = 2'b11; x.d = {32'd11, 32'd2}; run_cycle("ar1", x, 1'b0, 16'd0, 1'b0);
        x.v = 2'b11; x.d = {32'd12, 32'd3}; run_cycle("ar2", x, 1'b0, 16'd0, 1'b0);
        x.v = 2'b10; x.d = {32'd13, 32'd0}; run_cycle("ar3", x, 1'b0, 16'd0, 1'b0);
        x.v = 2'b00; x.d = '0;              run_cycle("ar4", x, 1'b0, 16'd0, 1'b1);
        model_check("ar5");
        chk("ar5.rows_buffered", W'(row_valid), W'(1));
        drive('0, '0, 1'b0, 16'd0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst.row_valid", W'(row_valid), W'(0));
        chk("async_rst.rows_out_cnt", W'(rows_out_cnt), W'(0));
        chk("async_rst.row_data", pack_row(), '0);
        tick();
        rst = 1'b1;

        // First row after release follows normal deskew latency
        chk("post_rst.c0.row_valid", W'(row_valid), W'(0));
        drive(2'b01, {32'd0, 32'd77}, 1'b0, 16'd0, 1'b0);
        tick();
        chk("post_rst.c1.row_valid", W'(row_valid), W'(0));
        drive(2'b10, {32'd88, 32'd0}, 1'b0, 16'd0, 1'b0);
        tick();
        chk("post_rst.c2.row_valid", W'(row_valid), W'(1));
        chk("post_rst.c2.row_data", pack_row(), {32'd88, 32'd77});
        chk("post_rst.c2.skew_err", W'(skew_err), W'(0));
        drive('0, '0, 1'b0, 16'd0, 1'b1);
        tick();
        chk("post_rst.c3.row_valid", W'(row_valid), W'(0));
        chk("post_rst.c3.rows_out_cnt", W'(rows_out_cnt), W'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
